// File: rtl/dr_alm_pipe_mult.sv
// Three-stage pipelined DR-ALM approximate logarithmic multiplier with
// signed/unsigned operands, optional truncation compensation and a pass-through tag.
module dr_alm_pipe_mult #(
    parameter int WIDTH   = 16,
    parameter int M_WIDTH = 10,
    parameter int TAG_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    input  logic                 i_signed,
    input  logic                 i_comp_en,
    input  logic [TAG_W-1:0]     i_tag,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [2*WIDTH-1:0]   o_z,
    output logic [TAG_W-1:0]     o_tag
);

    localparam int R  = WIDTH - 1 - M_WIDTH;
    localparam int KW = $clog2(WIDTH);
    localparam int EW = 2*WIDTH + M_WIDTH + 2;
    localparam logic [R:0] TR_TH = (R+1)'(3 << (R-2));

    // Magnitude of an operand; -2^(WIDTH-1) maps to 2^(WIDTH-1) in WIDTH bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [KW-1:0] lod(input logic [WIDTH-1:0] v);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) k = KW'(i);
        end
        return k;
    endfunction

    // Mitchell antilog; the right shift by M_WIDTH truncates.
    function automatic logic [2*WIDTH-1:0] antilog(input logic [M_WIDTH:0] s,
                                                   input logic [KW:0]     k,
                                                   input logic            zero);
        logic [EW-1:0] ext;
        if (s[M_WIDTH]) begin
            ext = EW'(s) << (k + 1'b1);
        end else begin
            ext = (EW'(s) + (EW'(1) << M_WIDTH)) << k;
        end
        ext = ext >> M_WIDTH;
        return zero ? '0 : ext[2*WIDTH-1:0];
    endfunction

    logic                 w_adv;
    logic                 w_sign_a, w_sign_b;
    logic [WIDTH-1:0]     w_abs_a, w_abs_b;

    logic                 r_vld_p0, r_sgn_p0, r_zero_p0, r_comp_en_p0;
    logic [KW-1:0]        r_ka_p0, r_kb_p0;
    logic [WIDTH-1:0]     r_abs_a_p0, r_abs_b_p0;
    logic [TAG_W-1:0]     r_tag_p0;

    logic [WIDTH-2:0]     w_frac_a, w_frac_b;
    logic [M_WIDTH-1:0]   w_ft_a, w_ft_b;
    logic [R-1:0]         w_tr_a, w_tr_b;
    logic [R:0]           w_tr_sum;
    logic                 w_comp;
    logic [M_WIDTH:0]     w_s;
    logic [KW:0]          w_k;

    logic                 r_vld_p1, r_sgn_p1, r_zero_p1;
    logic [M_WIDTH:0]     r_s_p1;
    logic [KW:0]          r_k_p1;
    logic [TAG_W-1:0]     r_tag_p1;

    logic [2*WIDTH-1:0]   w_mag, w_z;

    logic                 r_vld_p2;
    logic [2*WIDTH-1:0]   r_z_p2;
    logic [TAG_W-1:0]     r_tag_p2;

    assign w_adv   = !r_vld_p2 || o_ready;
    assign i_ready = w_adv;

    // Stage 1: sign extraction, magnitude and leading-one detection
    assign w_sign_a = i_signed & i_a[WIDTH-1];
    assign w_sign_b = i_signed & i_b[WIDTH-1];
    assign w_abs_a  = magnitude(i_a, w_sign_a);
    assign w_abs_b  = magnitude(i_b, w_sign_b);

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_sgn_p0     <= w_sign_a ^ w_sign_b;
            r_zero_p0    <= (w_abs_a == '0) || (w_abs_b == '0);
            r_ka_p0      <= lod(w_abs_a);
            r_kb_p0      <= lod(w_abs_b);
            r_abs_a_p0   <= w_abs_a;
            r_abs_b_p0   <= w_abs_b;
            r_comp_en_p0 <= i_comp_en;
            r_tag_p0     <= i_tag;
        end
    end

    // Stage 2: normalise, truncate mantissas, add logs
    assign w_frac_a = (WIDTH-1)'(r_abs_a_p0 << (KW'(WIDTH-1) - r_ka_p0));
    assign w_frac_b = (WIDTH-1)'(r_abs_b_p0 << (KW'(WIDTH-1) - r_kb_p0));
    assign w_ft_a   = w_frac_a[WIDTH-2:R];
    assign w_ft_b   = w_frac_b[WIDTH-2:R];
    assign w_tr_a   = w_frac_a[R-1:0];
    assign w_tr_b   = w_frac_b[R-1:0];
    assign w_tr_sum = {1'b0, w_tr_a} + {1'b0, w_tr_b};
    assign w_comp   = r_comp_en_p0 && (r_ka_p0 >= KW'(3)) && (r_kb_p0 >= KW'(3))
                      && (w_tr_sum >= TR_TH);
    assign w_s      = {1'b0, w_ft_a} + {1'b0, w_ft_b} + {{M_WIDTH{1'b0}}, w_comp};
    assign w_k      = {1'b0, r_ka_p0} + {1'b0, r_kb_p0};

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_sgn_p1  <= r_sgn_p0;
            r_zero_p1 <= r_zero_p0;
            r_s_p1    <= w_s;
            r_k_p1    <= w_k;
            r_tag_p1  <= r_tag_p0;
        end
    end

    // Stage 3: antilog and sign application
    assign w_mag = antilog(r_s_p1, r_k_p1, r_zero_p1);
    assign w_z   = r_sgn_p1 ? (~w_mag + 1'b1) : w_mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_z_p2   <= '0;
            r_tag_p2 <= '0;
        end else if (w_adv) begin
            r_vld_p0 <= i_valid;
            r_vld_p1 <= r_vld_p0;
            r_vld_p2 <= r_vld_p1;
            r_z_p2   <= w_z;
            r_tag_p2 <= r_tag_p1;
        end
    end

    assign o_valid = r_vld_p2;
    assign o_z     = r_z_p2;
    assign o_tag   = r_tag_p2;

endmodule

// File: tb/tb_dr_alm_pipe_mult.sv
// Randomised bench for dr_alm_pipe_mult with an arithmetic reference model and
// a scoreboard that checks every output cycle, plus directed literal cases.
module tb_dr_alm_pipe_mult;

    localparam int W  = 16;
    localparam int M  = 10;
    localparam int TW = 4;
    localparam int R  = W - 1 - M;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_valid;
    logic            i_ready;
    logic [W-1:0]    i_a, i_b;
    logic            i_signed, i_comp_en;
    logic [TW-1:0]   i_tag;
    logic            o_valid;
    logic            o_ready;
    logic [2*W-1:0]  o_z;
    logic [TW-1:0]   o_tag;

    int checks = 0;
    int errors = 0;
    bit rand_ready = 0;

    logic [2*W-1:0]  exp_z_q[$];
    logic [TW-1:0]   exp_tag_q[$];

    dr_alm_pipe_mult #(.WIDTH(W), .M_WIDTH(M), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_ready(i_ready),
        .i_a(i_a), .i_b(i_b), .i_signed(i_signed), .i_comp_en(i_comp_en), .i_tag(i_tag),
        .o_valid(o_valid), .o_ready(o_ready), .o_z(o_z), .o_tag(o_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: log-domain approximation from plain integer arithmetic.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input bit s, input bit c);
        longint unsigned ua, ub, fa, fb, sum_s, mag, rmod;
        int ka, kb, kk;
        bit sa, sb, comp;
        sa = s && a[W-1];
        sb = s && b[W-1];
        ua = sa ? (64'd65536 - 64'(a)) : 64'(a);
        ub = sb ? (64'd65536 - 64'(b)) : 64'(b);
        if (ua == 0 || ub == 0) return '0;
        ka = 0;
        while ((ua >> (ka + 1)) != 0) ka++;
        kb = 0;
        while ((ub >> (kb + 1)) != 0) kb++;
        fa = (ua - (64'd1 << ka)) << (W - 1 - ka);
        fb = (ub - (64'd1 << kb)) << (W - 1 - kb);
        rmod = 64'd1 << R;
        comp = c && ka >= 3 && kb >= 3 && ((fa % rmod) + (fb % rmod) >= 3 * (rmod / 4));
        sum_s = fa / rmod + fb / rmod + 64'(comp);
        kk = ka + kb;
        if (sum_s < (64'd1 << M)) mag = (((64'd1 << M) + sum_s) << kk) >> M;
        else                      mag = (sum_s << (kk + 1)) >> M;
        return (sa ^ sb) ? 32'(64'd0 - mag) : 32'(mag);
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'h0001;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            4:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Scoreboard and protocol monitor, sampled mid-cycle.
    logic [2*W-1:0] prev_z;
    logic [TW-1:0]  prev_tag;
    bit             prev_stall = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            chk("i_ready_rule", 64'(i_ready), 64'(!o_valid || o_ready));
            if (prev_stall) begin
                chk("hold_valid", 64'(o_valid), 64'd1);
                chk("hold_z", 64'(o_z), 64'(prev_z));
                chk("hold_tag", 64'(o_tag), 64'(prev_tag));
            end
            if (o_valid) begin
                if (exp_z_q.size() == 0) begin
                    chk("spurious_valid", 64'(o_valid), 64'd0);
                end else begin
                    chk("o_z", 64'(o_z), 64'(exp_z_q[0]));
                    chk("o_tag", 64'(o_tag), 64'(exp_tag_q[0]));
                    if (o_ready) begin
                        void'(exp_z_q.pop_front());
                        void'(exp_tag_q.pop_front());
                    end
                end
            end
            if (i_valid && i_ready) begin
                exp_z_q.push_back(model(i_a, i_b, i_signed, i_comp_en));
                exp_tag_q.push_back(i_tag);
            end
            prev_stall = o_valid && !o_ready;
            prev_z     = o_z;
            prev_tag   = o_tag;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) o_ready = 1'($urandom_range(0, 1));
    endtask

    // Presents one transaction and returns just after the edge that accepts it.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                        input bit c, input logic [TW-1:0] tag);
        bit hs;
        int n;
        hs = 0;
        n  = 0;
        i_valid = 1'b1; i_a = a; i_b = b; i_signed = s; i_comp_en = c; i_tag = tag;
        do begin
            @(negedge clk);
            hs = i_ready;
            tick();
            n++;
        end while (!hs && n < 50);
        if (!hs) chk("accept_timeout", 64'(hs), 64'd1);
    endtask

    task automatic expect_out(input string name, input logic [2*W-1:0] ez, input logic [TW-1:0] et);
        bit got;
        got = 0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (o_valid) begin
                chk(name, 64'(o_z), 64'(ez));
                chk({name, "_tag"}, 64'(o_tag), 64'(et));
                got = 1;
            end
        end
        if (!got) chk({name, "_timeout"}, 64'(got), 64'd1);
        tick();
    endtask

    task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit s, input bit c, input logic [TW-1:0] tag,
                            input logic [2*W-1:0] ez);
        send(a, b, s, c, tag);
        i_valid = 1'b0;
        expect_out(name, ez, tag);
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 400 && exp_z_q.size() != 0; n++) tick();
        chk(name, 64'(exp_z_q.size()), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_a = '0; i_b = '0; i_signed = 1'b0;
        i_comp_en = 1'b0; i_tag = '0; o_ready = 1'b1;
        #1;
        chk("rst_o_valid", 64'(o_valid), 64'd0);
        chk("rst_o_z", 64'(o_z), 64'd0);
        chk("rst_o_tag", 64'(o_tag), 64'd0);
        chk("rst_i_ready", 64'(i_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Latency: three edges from acceptance to o_valid
        send(16'd3, 16'd5, 1'b1, 1'b1, 4'd1);
        i_valid = 1'b0;
        chk("lat_edge1_valid", 64'(o_valid), 64'd0);
        tick();
        chk("lat_edge2_valid", 64'(o_valid), 64'd0);
        tick();
        chk("lat_edge3_valid", 64'(o_valid), 64'd1);
        chk("lat_o_z", 64'(o_z), 64'd14);
        chk("lat_o_tag", 64'(o_tag), 64'd1);
        tick();

        directed("neg3x5",      16'hFFFD, 16'd5,     1'b1, 1'b1, 4'd2,  32'hFFFFFFF2);
        directed("3x3_carry",   16'd3,    16'd3,     1'b1, 1'b1, 4'd3,  32'd8);
        directed("max_comp",    16'h7FFF, 16'h7FFF,  1'b1, 1'b1, 4'd4,  32'd1073217536);
        directed("max_nocomp",  16'h7FFF, 16'h7FFF,  1'b1, 1'b0, 4'd5,  32'd1072693248);
        directed("min_signed",  16'h8000, 16'd1,     1'b1, 1'b1, 4'd6,  32'hFFFF8000);
        directed("8000_unsig",  16'h8000, 16'd1,     1'b0, 1'b1, 4'd7,  32'd32768);
        directed("zero_a",      16'd0,    16'd1234,  1'b1, 1'b1, 4'd8,  32'd0);
        directed("zero_b_neg",  16'hFFFB, 16'd0,     1'b1, 1'b0, 4'd9,  32'd0);
        directed("zero_both",   16'd0,    16'd0,     1'b0, 1'b1, 4'd10, 32'd0);

        // Back-to-back burst, tags 0..7, with random backpressure
        rand_ready = 1;
        for (int t = 0; t < 8; t++)
            send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(t));
        i_valid = 1'b0;
        drain("burst_drain");

        // Long random run with bubbles and mixed modes
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                i_valid = 1'b0;
                tick();
            end else begin
                send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     4'($urandom));
            end
        end
        i_valid = 1'b0;
        drain("random_drain");

        // Asynchronous reset with three transactions in flight
        rand_ready = 0;
        o_ready = 1'b1;
        tick();
        send(16'd100, 16'd200, 1'b0, 1'b1, 4'd11);
        send(16'hFF00, 16'd7, 1'b1, 1'b0, 4'd12);
        send(16'd9, 16'd9, 1'b0, 1'b1, 4'd13);
        i_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(o_valid), 64'd0);
        chk("async_rst_z", 64'(o_z), 64'd0);
        chk("async_rst_tag", 64'(o_tag), 64'd0);
        exp_z_q.delete();
        exp_tag_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            chk("post_rst_no_stale", 64'(o_valid), 64'd0);
        end
        directed("post_rst_3x5", 16'd3, 16'd5, 1'b1, 1'b1, 4'd14, 32'd14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dr_alm_pipe_mult.md
Name: dr_alm_pipe_mult

Overview:
- Parametrised, 3-stage pipelined successor to the combinational 16-bit DR-ALM approximate log multiplier.
- Generalised to WIDTH-bit operands and to selectable signed/unsigned mode.
- Mantissa truncation compensation can be enabled per transaction.
- Valid/ready handshake on input and output, plus a tag carried alongside each product. Sits between the operand buffers and the accumulator in the approximate MAC datapath.

Parameters:
- WIDTH, 16, operand width; legal range 8..32.
- M_WIDTH, 10, kept mantissa bits; R = WIDTH-1-M_WIDTH must be >= 2.
- TAG_W, 4, width of the user tag passed through alongside each product.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  input operands valid
- i_ready  out  1  block can accept the input this cycle
- i_a  in  WIDTH  operand A
- i_b  in  WIDTH  operand B
- i_signed  in  1  1 = two's complement operands, 0 = unsigned
- i_comp_en  in  1  enable truncation compensation
- i_tag  in  TAG_W  user tag
- o_valid  out  1  product valid
- o_ready  in  1  downstream accepts the product
- o_z  out  2*WIDTH  product; two's complement when the transaction was signed
- o_tag  out  TAG_W  tag of the transaction on o_z

Behaviour:
- Reset (asynchronous, rst_n=0): all stage valid flags = 0; o_valid = 0; o_z = 0; o_tag = 0. Reset mid-operation discards all in-flight transactions.
- Global advance: adv = !o_valid || o_ready.
  - i_ready = adv, combinational.
  - Every stage register loads only when adv=1; bubbles travel as valid=0.
  - A transfer occurs on i_valid && i_ready.
- Latency and throughput: the product appears 3 cycles after input acceptance when not stalled. Throughput is 1 per cycle.
- Stall hold: while o_valid=1 and o_ready=0, o_z, o_tag and all stage contents hold stable.
- Mode: i_signed, i_comp_en and i_tag are sampled with the operands and travel with them. Mode may change every cycle.
- S1 (sign and LOD):
  - Signed mode: sign = MSB of each operand; abs = magnitude held in WIDTH bits, so -2^(WIDTH-1) gives 2^(WIDTH-1).
  - Unsigned mode: abs = raw operand; sign = 0.
  - sign_z = sign_a ^ sign_b.
  - k = index of the leading one of abs (0..WIDTH-1).
  - zero flag = (abs_a==0 || abs_b==0).
- S2 (normalise, truncate, add):
  - frac = (abs << (WIDTH-1-k))[WIDTH-2:0].
  - ft = frac[WIDTH-2:R], i.e. the top M_WIDTH bits; tr = frac[R-1:0].
  - comp = i_comp_en && k_a>=3 && k_b>=3 && (tr_a+tr_b) >= 3*2^(R-2).
  - S = ft_a + ft_b + comp, computed in M_WIDTH+1 bits; K = k_a + k_b.
- S3 (Mitchell antilog and sign):
  - If S < 2^M_WIDTH: mag = ((2^M_WIDTH + S) << K) >> M_WIDTH.
  - Else: mag = (S << (K+1)) >> M_WIDTH.
  - Right shifts truncate. Intermediates are wide enough that nothing overflows.
  - If the zero flag is set, mag = 0.
  - o_z = sign_z ? -mag : mag, in 2*WIDTH bits.
- Other boundaries:
  - i_valid=0 with adv=1 inserts a bubble.
  - Input is accepted in the same cycle the output is consumed: full rate, no lost or duplicated transaction.
  - Back-to-back accepts under intermittent o_ready preserve order and tags.

Test Plan (WIDTH=16, M_WIDTH=10):
- Reset, then signed a=3, b=5, comp_en=1, tag=1, o_ready=1 -> o_valid exactly 3 cycles later; o_z=14; o_tag=1.
- Signed a=-3, b=5 -> o_z=32'hFFFFFFF2. Signed a=3, b=3 -> o_z=8 (carry path).
- Signed a=b=16'h7FFF: comp_en=1 -> o_z=1073217536; comp_en=0 -> o_z=1072693248.
- Signed a=16'h8000, b=1 -> o_z=32'hFFFF8000. Unsigned a=16'h8000, b=1 -> o_z=32768. Any zero operand -> o_z=0.
- 8 back-to-back inputs with tags 0..7, o_ready toggled pseudo-randomly:
  - o_z and o_tag hold while stalled.
  - i_ready==(!o_valid||o_ready) every cycle.
  - Outputs appear in order 0..7 with none dropped or duplicated.
- rst_n pulsed low asynchronously with 3 transactions in flight -> o_valid=0 and o_z=0 immediately; no stale product afterward.
